// File: rtl/uart_word_loader_pkg.sv
// Shared types and constants for the UART-to-memory word loader.
package uart_word_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BYTE = 2'd1,
    ST_GAP       = 2'd2,
    ST_WRITE     = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000000;
  localparam int unsigned BYTES_PER_WORD         = 4;
  localparam int unsigned LANE_IDX_W             = 2;
  localparam int unsigned WORD_W                 = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/uart_word_loader_byte_packer.sv
// Little-endian byte-lane insert register: din lands in lane lane_idx.
module uart_word_loader_byte_packer
  import uart_word_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [LANE_IDX_W-1:0] lane_idx,
  input  logic [7:0]            din,
  output logic [WORD_W-1:0]     word
);

  // Clear wins over load so a new load never sees lanes from a dropped word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (lane_idx == LANE_IDX_W'(i)) word[8*i +: 8] <= din;
      end
    end
  end

endmodule

// File: rtl/uart_word_loader.sv
// Pulls bytes from the UART RX FIFO, packs them into 32-bit words and writes
// them to consecutive memory words from a programmed base address.
module uart_word_loader
  import uart_word_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_BITS   = 20,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  output logic                  rx_rd,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [TIMEOUT_BITS-1:0] TIMER_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        remain_q;
  logic [LANE_IDX_W-1:0]   byte_idx_q;
  logic [TIMEOUT_BITS-1:0] timer_q;
  logic [WORD_W-1:0]       word;

  logic lane_last;
  logic accept, zero_load, capture, stall, stall_hit;
  logic gap_next_lane, gap_to_write, do_write, last_word;

  assign lane_last = (byte_idx_q == LANE_IDX_W'(BYTES_PER_WORD - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and per-cycle control strobes; rx_rd is the only combinational output.
  always_comb begin
    state_d       = state_q;
    rx_rd         = 1'b0;
    accept        = 1'b0;
    zero_load     = 1'b0;
    capture       = 1'b0;
    stall         = 1'b0;
    stall_hit     = 1'b0;
    gap_next_lane = 1'b0;
    gap_to_write  = 1'b0;
    do_write      = 1'b0;
    last_word     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (word_count == '0) zero_load = 1'b1;
          else                  state_d   = ST_WAIT_BYTE;
        end
      end
      ST_WAIT_BYTE: begin
        rx_rd = rx_ready;
        if (rx_ready) begin
          capture = 1'b1;
          state_d = ST_GAP;
        end else if (timer_q == TIMER_LAST) begin
          stall_hit = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      ST_GAP: begin
        if (lane_last) begin
          gap_to_write = 1'b1;
          state_d      = ST_WRITE;
        end else begin
          gap_next_lane = 1'b1;
          state_d       = ST_WAIT_BYTE;
        end
      end
      ST_WRITE: begin
        do_write = 1'b1;
        if (remain_q == CNT_W'(1)) begin
          last_word = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WAIT_BYTE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q        <= '0;
      remain_q      <= '0;
      byte_idx_q    <= '0;
      timer_q       <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      words_written <= '0;
    end else begin
      busy   <= (state_d != ST_IDLE);
      mem_we <= gap_to_write;
      done   <= zero_load | last_word;
      if (accept) begin
        addr_q        <= base_addr;
        remain_q      <= word_count;
        words_written <= '0;
        timeout_err   <= 1'b0;
        byte_idx_q    <= '0;
        timer_q       <= '0;
      end
      if (capture) timer_q <= '0;
      if (stall)   timer_q <= timer_q + TIMEOUT_BITS'(1);
      if (stall_hit) begin
        timeout_err <= 1'b1;
        timer_q     <= '0;
      end
      if (gap_next_lane) byte_idx_q <= byte_idx_q + LANE_IDX_W'(1);
      if (gap_to_write) begin
        mem_addr  <= addr_q;
        mem_wdata <= word;
      end
      if (do_write) begin
        addr_q        <= addr_q + ADDR_WIDTH'(1);
        remain_q      <= remain_q - CNT_W'(1);
        words_written <= words_written + CNT_W'(1);
        byte_idx_q    <= '0;
      end
    end
  end

  uart_word_loader_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .load     (capture),
    .lane_idx (byte_idx_q),
    .din      (rx_data),
    .word     (word)
  );

endmodule

// File: doc/uart_word_loader.md
Name: uart_word_loader

Overview:
Consumes received bytes from the UART receive FIFO through its ready/rd interface and assembles them little-endian into 32-bit words. Writes each word to the memory bank at consecutive word addresses from a programmed base. Sits directly downstream of the UART receiver, between it and the MEMBANK write port, and is used for host-driven memory loading. One start loads a fixed word count and reports done, or reports timeout if the byte stream stalls.

Parameters:
ADDR_WIDTH, 10, memory word-address width
TIMEOUT_BITS, 20, width of the inter-byte stall timer
TIMEOUT_CYCLES, 1000000, stall limit in clk cycles (10 ms at 100 MHz); must fit in TIMEOUT_BITS

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous reset, active-low (rst=0 resets)
start  in  1  one-cycle load request; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first word address; latched on accepted start
word_count  in  ADDR_WIDTH+1  number of words to load; latched on accepted start
rx_ready  in  1  UART FIFO non-empty; rx_data holds the head byte
rx_data  in  8  UART FIFO head byte (show-ahead)
rx_rd  out  1  pop strobe to the UART FIFO
mem_we  out  1  one-cycle memory write strobe
mem_addr  out  ADDR_WIDTH  write word address
mem_wdata  out  32  write data
busy  out  1  high while a load is in progress
done  out  1  one-cycle pulse on successful completion
timeout_err  out  1  sticky stall flag; cleared by the next accepted start
words_written  out  ADDR_WIDTH+1  words written since the last accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs and internal registers are 0.
  - A partially assembled word is discarded.
  - rx_rd=0 during reset.
- States: IDLE, WAIT_BYTE, GAP, WRITE.
- IDLE:
  - busy=0.
  - On start=1, latch base_addr into addr, word_count into remain, clear words_written, timeout_err, byte_idx and timer.
  - If word_count=0, pulse done next cycle and stay in IDLE. Otherwise go to WAIT_BYTE.
- WAIT_BYTE:
  - rx_rd = rx_ready (combinational, this state only).
  - When rx_ready=1, rx_data is captured into lane byte_idx (byte 0 -> bits 7:0, byte 3 -> bits 31:24), the timer is cleared, and the FSM goes to GAP.
  - When rx_ready=0, the timer increments. At timer = TIMEOUT_CYCLES-1, set timeout_err=1, go to IDLE, and assert no done. The partial word is dropped and memory is not written.
- GAP:
  - Exactly one cycle. rx_ready is not sampled, giving the FIFO one cycle of pop recovery.
  - If byte_idx=3, go to WRITE. Otherwise increment byte_idx and return to WAIT_BYTE.
- WRITE:
  - mem_we=1 for exactly one cycle; mem_addr=addr; mem_wdata=assembled word. Memory always accepts the write.
  - On the next edge: addr+1 (wraps modulo 2^ADDR_WIDTH), remain-1, words_written+1, byte_idx=0.
  - If remain was 1, go to IDLE and pulse done in that same transition cycle. Otherwise go to WAIT_BYTE.
- Latency and throughput:
  - The 4th byte's rx_rd in cycle N produces mem_we in cycle N+2.
  - Minimum 9 cycles per word (4x(rd+gap)+write).
- mem_addr and mem_wdata hold their last values outside WRITE. mem_we and done are 0 outside their pulse cycles.
- start while busy is ignored. Excess bytes in the FIFO after completion are left unread.
- words_written and the timeout_err state stay readable until the next accepted start.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE=2'd0, WAIT_BYTE=2'd1, GAP=2'd2, WRITE=2'd3).
  - Default TIMEOUT_CYCLES.
  - Byte-lane constant of 4 bytes per word.
- One natural sub-module: byte_packer, a 4-lane little-endian shift/insert register with a byte_idx input and clear.
- The stall timer stays inline.

Test Plan:
1. Reset then start (base=0x010, count=2) with FIFO bytes 11 22 33 44 55 66 77 88 -> mem_we at 0x010 data 0x44332211, then at 0x011 data 0x88776655; done pulses once; words_written=2; timeout_err=0.
2. start with count=0 -> done pulses 1 cycle later, rx_rd never asserted, no mem_we.
3. base=0x3FF, count=2 -> writes land at 0x3FF then 0x000 (address wrap).
4. 2 bytes supplied then rx_ready held low with TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 stalled cycles, busy=0, no mem_we, no done. The next start clears timeout_err.
5. rx_ready held high continuously -> rx_rd is never high in two consecutive cycles; mem_we follows the 4th rd by exactly 2 cycles; 9 cycles per word.
6. rst pulled low mid-word (after 2 bytes) -> all outputs 0 immediately. After release, a new start with 4 bytes AA BB CC DD writes 0xDDCCBBAA with no stale data.
